operand_fetch: RTL and testbench
================================

# operand_fetch

Decode-to-execute operand fetch stage for the RV32 core. Accepts one decoded instruction per cycle over a valid/ready handshake and drives the register file's two combinational read ports. Tracks pending destination writes in a scoreboard and bypasses same-cycle writeback data. Presents a registered operand bundle to execute over a second valid/ready handshake.

## Interface
- `XLEN`, 32: datapath width.
- `NREG`, 32: architectural register count; index width is log2(NREG) = 5.

- `clk` in 1: single core clock, all state updates on the rising edge.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `in_valid` in 1: decoded instruction present.
- `in_ready` out 1: stage accepts the instruction this cycle.
- `in_rs1`, `in_rs2` in 5: source indices.
- `in_rs1_used`, `in_rs2_used` in 1: the source is actually read.
- `in_rd` in 5: destination index.
- `in_rd_wr` in 1: instruction writes rd.
- `in_pc`, `in_imm` in XLEN: carried through.
- `rf_rd_en1`, `rf_rd_en2` out 1: register file read enables.
- `rf_rd_index1`, `rf_rd_index2` out 5: register file read indices.
- `rf_rd_data1`, `rf_rd_data2` in XLEN: register file read data, combinational.
- `wb_valid` in 1: writeback commits this cycle (same strobe as register file wr_en).
- `wb_index` in 5, `wb_data` in XLEN: writeback target and value.
- `flush` in 1: squash the held output instruction.
- `out_valid` out 1, `out_ready` in 1: execute-side handshake.
- `out_rs1_val`, `out_rs2_val`, `out_pc`, `out_imm` out XLEN; `out_rd` out 5; `out_rd_wr` out 1: the registered bundle.

## Operation
- Scoreboard: `busy[NREG-1:0]`. `busy[0]` is hardwired to 0.
- Read ports:
  - `rf_rd_en1 = in_valid & in_rs1_used`.
  - `rf_rd_index1 = in_rs1`.
  - Port 2 is identical, using rs2.
- Bypass per source:
  - index 0 gives 0;
  - otherwise, if `wb_valid & wb_index==rs`, use `wb_data`;
  - otherwise use `rf_rd_data`.
  - Bypass is needed because the register file writes at the edge, so a same-cycle read returns the old value.
- A source is "clear" if it is unused, or its index is 0, or `!busy[rs]`, or `wb_valid & wb_index==rs`.
- RAW stall: either source is not clear.
- WAW stall: `in_rd_wr & in_rd!=0 & busy[rd]`, and not cleared by a writeback this cycle.
- `in_ready = !reset & !flush & !stall & (!out_valid | out_ready)`.
- Accept (`in_valid & in_ready`):
  - the output register loads the bundle with bypassed operands;
  - `out_valid` is set;
  - `busy[in_rd]` is set if `in_rd_wr & in_rd!=0`.
- Drain: `out_valid & out_ready` with no new accept clears `out_valid`. The bundle data holds its last value.
- Writeback: clears `busy[wb_index]`.
  - If an accept sets the same index in the same cycle, the set wins.
- Flush:
  - `out_valid` goes to 0 next edge;
  - if the held instruction has `out_rd_wr & out_rd!=0`, that `busy` bit is cleared;
  - no accept occurs in the flush cycle.
  - Instructions already past execute are not affected; their writebacks still clear busy.
- `out_rd_wr` with `out_rd==0` passes through unchanged; the register file/writeback ignores x0 only via the scoreboard here.

## Timing
- Reset values: `out_valid=0`, all `busy=0`, all `out_*` data 0, `in_ready=0` while `reset` is high. Reset asserted mid-stream drops the held instruction.
- Latency: accept at edge N gives `out_valid` high after edge N. Full throughput, one per cycle, when no hazards and `out_ready=1`.
- Back-pressure: with `out_ready=0` and `out_valid=1`, `in_ready=0` and the bundle is stable.
- `in_ready` depends combinationally on `in_*`, `wb_*`, `flush` and `out_ready`. `out_*` are registered only.
- Hazard resolution: an instruction stalled on a busy rs is accepted in the same cycle as the matching writeback, using `wb_data`.

## Structure
- Shared package `rv_pkg`:
  - `XLEN`;
  - `reg_idx_t` (5-bit);
  - `fetch_bundle_t` struct (rs1_val, rs2_val, rd, rd_wr, pc, imm).
- Sub-module `scoreboard`:
  - busy vector;
  - set port (accept), clear ports (writeback, flush);
  - combinational `is_busy` lookups for rs1, rs2 and rd, with the set-over-clear priority defined in Operation.
- The top level holds the handshake logic, the bypass muxes and the output register.

## Test plan
- Independent stream:
  - stimulus: ADD x3←x1,x2 then ADD x4←x5,x6, `out_ready=1`; register file holds x1=5, x2=7;
  - response: both accepted back-to-back, `out_rs1_val=5`, `out_rs2_val=7`, `busy[3]` and `busy[4]` set.
- RAW stall:
  - stimulus: write x3 in flight; a reader of x3 is presented; `wb_valid`, index 3, data 0x1234 arrives 3 cycles later;
  - response: `in_ready=0` for 3 cycles, accepted in the writeback cycle with `out_rs1_val=0x1234`, `busy[3]` cleared.
- x0 handling:
  - stimulus: rs1=0 with `busy` forced on other registers; writer with rd=0;
  - response: no stall, operand 0, `busy[0]` stays 0.
- Back-pressure:
  - stimulus: `out_ready=0` for 4 cycles with `in_valid=1`;
  - response: `out_*` stable, `in_ready=0`, and the next instruction is accepted the cycle `out_ready` returns.
- Flush:
  - stimulus: held instruction writes x9, `flush=1` for one cycle;
  - response: `out_valid=0` next cycle, `busy[9]=0`, no accept in the flush cycle.
- Reset mid-operation:
  - stimulus: `reset` asserted with `out_valid=1` and several busy bits set;
  - response: after one edge, `out_valid=0`, all busy bits 0, `in_ready=0` until reset drops.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32 core types: datapath width, register index and operand bundle.
package rv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NREG      = 32;
  localparam int unsigned REG_IDX_W = $clog2(NREG);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    reg_idx_t        rd;
    logic            rd_wr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
  } fetch_bundle_t;

  // Source operand select: x0 reads zero, then same-cycle writeback, then register file.
  function automatic logic [XLEN-1:0] bypass(input reg_idx_t        rs,
                                             input logic            wb_valid,
                                             input reg_idx_t        wb_index,
                                             input logic [XLEN-1:0] wb_data,
                                             input logic [XLEN-1:0] rf_data);
    logic [XLEN-1:0] val;
    if (rs == '0)                          val = '0;
    else if (wb_valid && wb_index == rs)   val = wb_data;
    else                                   val = rf_data;
    return val;
  endfunction

endpackage

// File: rtl/scoreboard.sv
// Pending-destination scoreboard; lookups already see this cycle's writeback as done.
module scoreboard
  import rv_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     set_en,
  input  reg_idx_t set_index,
  input  logic     wb_en,
  input  reg_idx_t wb_index,
  input  logic     flush_en,
  input  reg_idx_t flush_index,
  input  reg_idx_t rs1,
  input  reg_idx_t rs2,
  input  reg_idx_t rd,
  output logic     rs1_busy_c,
  output logic     rs2_busy_c,
  output logic     rd_busy_c
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;

  // Lookups: a register being written back this cycle is no longer pending.
  always_comb begin
    rs1_busy_c = busy[rs1] && !(wb_en && wb_index == rs1);
    rs2_busy_c = busy[rs2] && !(wb_en && wb_index == rs2);
    rd_busy_c  = busy[rd]  && !(wb_en && wb_index == rd);
  end

  // Next busy vector: clears first so a same-cycle set wins; x0 never pending.
  always_comb begin
    busy_next = busy;
    if (wb_en)    busy_next[wb_index]    = 1'b0;
    if (flush_en) busy_next[flush_index] = 1'b0;
    if (set_en)   busy_next[set_index]   = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Busy state register.
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: register file read, hazard stall, writeback bypass, output register.
module operand_fetch
  import rv_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_IDX_W-1:0] in_rs1,
  input  logic [REG_IDX_W-1:0] in_rs2,
  input  logic                 in_rs1_used,
  input  logic                 in_rs2_used,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic                 in_rd_wr,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [XLEN-1:0]      in_imm,
  output logic                 rf_rd_en1,
  output logic                 rf_rd_en2,
  output logic [REG_IDX_W-1:0] rf_rd_index1,
  output logic [REG_IDX_W-1:0] rf_rd_index2,
  input  logic [XLEN-1:0]      rf_rd_data1,
  input  logic [XLEN-1:0]      rf_rd_data2,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_index,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_rs1_val,
  output logic [XLEN-1:0]      out_rs2_val,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_imm,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic                 out_rd_wr
);

  logic          rs1_busy_c, rs2_busy_c, rd_busy_c;
  logic          rs1_clear_c, rs2_clear_c, waw_c, stall_c;
  logic          accept_c, set_en_c, flush_en_c;
  fetch_bundle_t next_c;
  fetch_bundle_t out_q;

  scoreboard u_sb (
    .clk         (clk),
    .reset       (reset),
    .set_en      (set_en_c),
    .set_index   (in_rd),
    .wb_en       (wb_valid),
    .wb_index    (wb_index),
    .flush_en    (flush_en_c),
    .flush_index (out_q.rd),
    .rs1         (in_rs1),
    .rs2         (in_rs2),
    .rd          (in_rd),
    .rs1_busy_c  (rs1_busy_c),
    .rs2_busy_c  (rs2_busy_c),
    .rd_busy_c   (rd_busy_c)
  );

  // Register file read ports follow the decoded sources directly.
  always_comb begin
    rf_rd_en1    = in_valid && in_rs1_used;
    rf_rd_en2    = in_valid && in_rs2_used;
    rf_rd_index1 = in_rs1;
    rf_rd_index2 = in_rs2;
  end

  // Hazard detection and input handshake.
  always_comb begin
    rs1_clear_c = !in_rs1_used || in_rs1 == '0 || !rs1_busy_c;
    rs2_clear_c = !in_rs2_used || in_rs2 == '0 || !rs2_busy_c;
    waw_c       = in_rd_wr && in_rd != '0 && rd_busy_c;
    stall_c     = !rs1_clear_c || !rs2_clear_c || waw_c;
    in_ready    = !reset && !flush && !stall_c && (!out_valid || out_ready);
    accept_c    = in_valid && in_ready;
    set_en_c    = accept_c && in_rd_wr && in_rd != '0;
    flush_en_c  = flush && out_valid && out_q.rd_wr && out_q.rd != '0;
  end

  // Bundle to load on accept, with bypassed operands.
  always_comb begin
    next_c         = '0;
    next_c.rs1_val = bypass(in_rs1, wb_valid, wb_index, wb_data, rf_rd_data1);
    next_c.rs2_val = bypass(in_rs2, wb_valid, wb_index, wb_data, rf_rd_data2);
    next_c.rd      = in_rd;
    next_c.rd_wr   = in_rd_wr;
    next_c.pc      = in_pc;
    next_c.imm     = in_imm;
  end

  // Output register: load on accept, drop on drain or flush; data holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (accept_c) begin
      out_valid <= 1'b1;
      out_q     <= next_c;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_rs1_val = out_q.rs1_val;
  assign out_rs2_val = out_q.rs2_val;
  assign out_pc      = out_q.pc;
  assign out_imm     = out_q.imm;
  assign out_rd      = out_q.rd;
  assign out_rd_wr   = out_q.rd_wr;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch with a register file model and output scoreboard.
module tb_operand_fetch;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic        in_rs1_used = 1'b0, in_rs2_used = 1'b0, in_rd_wr = 1'b0;
  logic [31:0] in_pc = '0, in_imm = '0;
  logic        rf_rd_en1, rf_rd_en2;
  logic [4:0]  rf_rd_index1, rf_rd_index2;
  logic [31:0] rf_rd_data1, rf_rd_data2;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_index = '0;
  logic [31:0] wb_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_rs1_val, out_rs2_val, out_pc, out_imm;
  logic [4:0]  out_rd;
  logic        out_rd_wr;

  int chk_cnt = 0;
  int pass_cnt = 0;

  logic [31:0]   rf [32];
  fetch_bundle_t exp_q [$];
  fetch_bundle_t mon_exp, mon_got;
  wire  [31:0]   busy_obs = u_dut.u_sb.busy;

  operand_fetch u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
    .in_rd(in_rd), .in_rd_wr(in_rd_wr), .in_pc(in_pc), .in_imm(in_imm),
    .rf_rd_en1(rf_rd_en1), .rf_rd_en2(rf_rd_en2),
    .rf_rd_index1(rf_rd_index1), .rf_rd_index2(rf_rd_index2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .wb_valid(wb_valid), .wb_index(wb_index), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_pc(out_pc), .out_imm(out_imm), .out_rd(out_rd), .out_rd_wr(out_rd_wr)
  );

  always #5 clk = ~clk;

  // Register file model: x0 returns garbage so the stage must zero it itself.
  assign rf_rd_data1 = (rf_rd_index1 == 5'd0) ? 32'hDEAD_BEEF : rf[rf_rd_index1];
  assign rf_rd_data2 = (rf_rd_index2 == 5'd0) ? 32'hDEAD_BEEF : rf[rf_rd_index2];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_valid && wb_index != 5'd0) begin
      rf[wb_index] <= wb_data;
    end
  end

  function automatic logic [31:0] model_val(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (wb_valid && wb_index == rs) return wb_data;
    return rf[rs];
  endfunction

  // Output monitor: just before each rising edge, pop/compare drained bundles, push accepted ones.
  always @(negedge clk) begin
    #4;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_valid && flush) begin
        if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
      end else if (out_valid && out_ready) begin
        mon_got.rs1_val = out_rs1_val;
        mon_got.rs2_val = out_rs2_val;
        mon_got.rd      = out_rd;
        mon_got.rd_wr   = out_rd_wr;
        mon_got.pc      = out_pc;
        mon_got.imm     = out_imm;
        chk_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL bundle_unexpected: pc=%h but nothing expected", out_pc);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp)
            $display("FAIL bundle pc=%h: got %h want %h", mon_exp.pc, mon_got, mon_exp);
          else pass_cnt++;
        end
      end
      if (in_valid && in_ready) begin
        mon_exp.rs1_val = model_val(in_rs1);
        mon_exp.rs2_val = model_val(in_rs2);
        mon_exp.rd      = in_rd;
        mon_exp.rd_wr   = in_rd_wr;
        mon_exp.pc      = in_pc;
        mon_exp.imm     = in_imm;
        exp_q.push_back(mon_exp);
      end
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic set_instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                           input logic u2, input logic [4:0] rd, input logic wr,
                           input logic [31:0] pc, input logic [31:0] imm);
    in_valid = 1'b1; in_rs1 = rs1; in_rs1_used = u1; in_rs2 = rs2; in_rs2_used = u2;
    in_rd = rd; in_rd_wr = wr; in_pc = pc; in_imm = imm;
  endtask

  task automatic wb(input logic [4:0] idx, input logic [31:0] data);
    step(); in_valid = 1'b0; wb_valid = 1'b1; wb_index = idx; wb_data = data;
    step(); wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    step(); #1;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if ({out_rs1_val, out_pc, out_imm} !== 96'd0) $display("FAIL rst_data: got %h want 0", {out_rs1_val, out_pc, out_imm}); else pass_cnt++;
    chk_cnt++; if (busy_obs !== 32'd0) $display("FAIL rst_busy: got %h want 0", busy_obs); else pass_cnt++;
    step(); reset = 1'b0; #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    wb(5'd1, 32'd5); wb(5'd2, 32'd7); wb(5'd5, 32'd11); wb(5'd6, 32'd13);
    out_ready = 1'b1;
    step(); set_instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 32'h100, 32'd1); #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_ready0: got %b want 1", in_ready); else pass_cnt++;
    chk_cnt++; if ({rf_rd_en1, rf_rd_en2, rf_rd_index1, rf_rd_index2} !== {1'b1, 1'b1, 5'd1, 5'd2})
      $display("FAIL b2b_rf_port: got %b%b %0d %0d want 11 1 2", rf_rd_en1, rf_rd_en2, rf_rd_index1, rf_rd_index2); else pass_cnt++;
    step(); set_instr(5'd5, 1'b1, 5'd6, 1'b1, 5'd4, 1'b1, 32'h104, 32'd2); #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_ready1: got %b want 1", in_ready); else pass_cnt++;
    chk_cnt++; if ({out_valid, out_rs1_val, out_rs2_val} !== {1'b1, 32'd5, 32'd7})
      $display("FAIL b2b_first: got %b %0d %0d want 1 5 7", out_valid, out_rs1_val, out_rs2_val); else pass_cnt++;
    step(); in_valid = 1'b0; #1;
    chk_cnt++; if ({out_rs1_val, out_rs2_val} !== {32'd11, 32'd13})
      $display("FAIL b2b_second: got %0d %0d want 11 13", out_rs1_val, out_rs2_val); else pass_cnt++;
    chk_cnt++; if (busy_obs[4:3] !== 2'b11) $display("FAIL b2b_busy: got %b want 11", busy_obs[4:3]); else pass_cnt++;
    step();
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", out_valid); else pass_cnt++;
    wb(5'd3, 32'd30); wb(5'd4, 32'd40);
  endtask

  task automatic test_raw();
    step(); set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 32'h200, 32'd0);
    step(); set_instr(5'd3, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 32'h204, 32'd9);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL raw_stall%0d: got %b want 0", i, in_ready); else pass_cnt++;
      step();
    end
    wb_valid = 1'b1; wb_index = 5'd3; wb_data = 32'h1234; #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL raw_wb_ready: got %b want 1", in_ready); else pass_cnt++;
    step(); in_valid = 1'b0; wb_valid = 1'b0; #1;
    chk_cnt++; if (out_rs1_val !== 32'h1234) $display("FAIL raw_bypass: got %h want 1234", out_rs1_val); else pass_cnt++;
    chk_cnt++; if ({busy_obs[7], busy_obs[3]} !== 2'b10) $display("FAIL raw_busy: got b7=%b b3=%b want 1 0", busy_obs[7], busy_obs[3]); else pass_cnt++;
    wb(5'd7, 32'd70);
  endtask

  task automatic test_waw();
    step(); set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 32'h280, 32'd0);
    step(); set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 32'h284, 32'd0); #1;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL waw_stall: got %b want 0", in_ready); else pass_cnt++;
    step(); wb_valid = 1'b1; wb_index = 5'd20; wb_data = 32'd200; #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL waw_wb_ready: got %b want 1", in_ready); else pass_cnt++;
    step(); in_valid = 1'b0; wb_valid = 1'b0; #1;
    chk_cnt++; if (busy_obs[20] !== 1'b1) $display("FAIL waw_set_wins: got %b want 1", busy_obs[20]); else pass_cnt++;
    wb(5'd20, 32'd201);
  endtask

  task automatic test_x0();
    step(); set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 32'h300, 32'd0);
    step(); set_instr(5'd0, 1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 32'h304, 32'd5); #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL x0_ready: got %b want 1", in_ready); else pass_cnt++;
    step(); in_valid = 1'b0; #1;
    chk_cnt++; if ({out_rs1_val, out_rd, out_rd_wr} !== {32'd0, 5'd0, 1'b1})
      $display("FAIL x0_bundle: got %h %0d %b want 0 0 1", out_rs1_val, out_rd, out_rd_wr); else pass_cnt++;
    chk_cnt++; if (busy_obs[1:0] !== 2'b10) $display("FAIL x0_busy: got %b want 10", busy_obs[1:0]); else pass_cnt++;
    wb(5'd1, 32'd5);
  endtask

  task automatic test_back_pressure();
    step(); set_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 32'h400, 32'd4);
    step(); out_ready = 1'b0; set_instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 32'h404, 32'd8);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_cnt++; if ({in_ready, out_valid, out_pc, out_rs1_val} !== {1'b0, 1'b1, 32'h400, 32'd5})
        $display("FAIL bp_hold%0d: got rdy=%b v=%b pc=%h rs1=%0d want 0 1 400 5", i, in_ready, out_valid, out_pc, out_rs1_val);
      else pass_cnt++;
      step();
    end
    out_ready = 1'b1; #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_resume: got %b want 1", in_ready); else pass_cnt++;
    step(); in_valid = 1'b0; #1;
    chk_cnt++; if (out_pc !== 32'h404) $display("FAIL bp_next: got %h want 404", out_pc); else pass_cnt++;
    wb(5'd10, 32'd100); wb(5'd11, 32'd110);
  endtask

  task automatic test_flush();
    step(); set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 32'h500, 32'd0);
    step(); out_ready = 1'b0; flush = 1'b1; set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 32'h504, 32'd0); #1;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", in_ready); else pass_cnt++;
    step(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if ({busy_obs[12], busy_obs[9]} !== 2'b00) $display("FAIL flush_busy: got b12=%b b9=%b want 0 0", busy_obs[12], busy_obs[9]); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    step(); set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 32'h600, 32'd0);
    step(); set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 32'h604, 32'd0);
    step(); out_ready = 1'b0; in_valid = 1'b0; #1;
    chk_cnt++; if ({out_valid, busy_obs[14:13]} !== 3'b111) $display("FAIL rstm_pre: got v=%b busy=%b want 1 11", out_valid, busy_obs[14:13]); else pass_cnt++;
    step(); reset = 1'b1; set_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 32'h608, 32'd0); #1;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL rstm_ready: got %b want 0", in_ready); else pass_cnt++;
    step();
    chk_cnt++; if ({out_valid, busy_obs, out_pc} !== 65'd0) $display("FAIL rstm_clear: got v=%b busy=%h pc=%h want 0", out_valid, busy_obs, out_pc); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL rstm_hold_ready: got %b want 0", in_ready); else pass_cnt++;
    step(); reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rstm_release: got %b want 1", in_ready); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_raw();
    test_waw();
    test_x0();
    test_back_pressure();
    test_flush();
    test_reset_mid();
    step(); step();
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL queue_empty: %0d left want 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
